decade_count_monitor: RTL and testbench
=======================================

Name: decade_count_monitor

Overview:
- Receiver-side checker for the 1-to-10 decade count stream driven by the decade counter.
- Samples a 4-bit count bus and locks onto the legal sequence 1,2,...,10,1,...
- Flags every out-of-sequence sample and counts completed decades (10->1 wraps).
- Used as an in-system monitor and as a self-checking block for counter benches.

Parameters:
LOCK_LEN, 3, consecutive in-sequence samples (first one included) needed to declare lock; legal range 2..15
UNLOCK_LEN, 2, consecutive mismatches while locked that drop lock; legal range 1..15
CNT_W, 8, width of err_count and wrap_count

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
count_in  input  4  count value from the decade counter
count_valid  input  1  count_in is sampled on a rising edge only when 1
locked  output  1  1 while the FSM is in LOCKED
expected  output  4  next value expected while locked; 0 otherwise
err_pulse  output  1  one-cycle pulse for each mismatch seen while locked
wrap_pulse  output  1  one-cycle pulse for each accepted 10->1 transition while locked
err_count  output  CNT_W  saturating count of err_pulse events
wrap_count  output  CNT_W  saturating count of wrap_pulse events

Behaviour:
- All state and outputs are registered. Outputs reflect the sample taken on the previous rising edge, so latency is 1 cycle.
- Reset (synchronous, active-high, takes priority over everything):
  - state=HUNT, prev=0, match=0, miss=0.
  - All outputs are 0.
  - Reset mid-stream discards lock and clears both counters.
- Definitions:
  - legal(v) = 1<=v<=10.
  - succ(v) = (v==10) ? 1 : v+1.
  - Values 0 and 11..15 are illegal.
- count_valid=0: all state and counters hold; err_pulse=0 and wrap_pulse=0.
- HUNT:
  - Legal sample v: prev<=v, match<=1, go to SYNC.
  - Illegal sample: stay in HUNT; no error is flagged.
- SYNC:
  - Sample v==succ(prev): prev<=v, match<=match+1. If match+1==LOCK_LEN, go to LOCKED, miss<=0.
  - Legal sample v!=succ(prev): prev<=v, match<=1, stay in SYNC (resync).
  - Illegal sample: go to HUNT, match<=0.
  - No err_pulse or wrap_pulse is generated in HUNT or SYNC.
- LOCKED:
  - expected = succ(prev).
  - Match (v==expected): prev<=v, miss<=0. If prev==10 and v==1, wrap_pulse=1 and wrap_count increments.
  - Mismatch (including illegal values): err_pulse=1, err_count increments, prev<=expected (flywheel: the expected sequence keeps advancing), miss<=miss+1.
  - If miss+1==UNLOCK_LEN: go to HUNT, locked<=0, prev<=0. The err_pulse for this final mismatch is still issued.
- Counters saturate at 2^CNT_W-1 and never wrap.
- locked=1 exactly when state==LOCKED.
- expected is forced to 0 outside LOCKED.
- FSM encoding uses 2 bits; the unused encoding recovers to HUNT on the next clock.

Test Plan:
- Reset, then valid stream 1,2,3,4...10,1,2: locked=1 in the cycle after the sample 3 is taken; expected=4 in that cycle; wrap_pulse=1 for one cycle after the sample 1 following 10; wrap_count=1; err_count=0.
- While locked and expecting 6, inject 9 once, then resume at 7: err_pulse=1 once; err_count=1; expected advances 6->7->8; lock is held (miss=1 < UNLOCK_LEN=2).
- While locked, inject two consecutive bad values (0, 15): err_count=2; locked falls to 0 after the second bad sample; expected=0. A subsequent 4,5,6 relocks with expected=7.
- Hold count_valid=0 for 5 cycles mid-stream while count_in changes arbitrarily: state, expected and both counters are unchanged; no pulses.
- Stream 1..10 repeated for 30 decades with CNT_W=4: wrap_count saturates at 15; no further change to wrap_count.
- Assert reset for 1 cycle while locked with err_count=3: the next cycle shows locked=0, err_count=0, wrap_count=0, expected=0. The stream then relocks after LOCK_LEN samples.

Source files
------------

// File: rtl/decade_count_monitor_if.sv
// Count-stream bus between a decade counter (master) and its sequence monitor (slave).
interface decade_count_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic [3:0]       count_in;
  logic             count_valid;
  logic             locked;
  logic [3:0]       expected;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;

  modport master (
    output count_in, count_valid,
    input  locked, expected, err_pulse, wrap_pulse, err_count, wrap_count
  );

  modport slave (
    input  count_in, count_valid,
    output locked, expected, err_pulse, wrap_pulse, err_count, wrap_count
  );
endinterface

// File: rtl/decade_count_monitor.sv
// Locks onto a 1..10 decade count stream, flags out-of-sequence samples and
// counts completed decades; all outputs registered with one cycle of latency.
module decade_count_monitor #(
  parameter int unsigned LOCK_LEN   = 3,
  parameter int unsigned UNLOCK_LEN = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  decade_count_monitor_if.slave mon
);

  localparam logic [3:0] LOCK_V   = 4'(LOCK_LEN);
  localparam logic [3:0] UNLOCK_V = 4'(UNLOCK_LEN);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_SYNC   = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  function automatic logic [3:0] succ(input logic [3:0] v);
    return (v == 4'd10) ? 4'd1 : 4'(v + 4'd1);
  endfunction

  state_t           r_state;
  logic [3:0]       r_prev;
  logic [3:0]       r_match;
  logic [3:0]       r_miss;
  logic             r_locked;
  logic [3:0]       r_expected;
  logic             r_err_pulse;
  logic             r_wrap_pulse;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_wrap_count;

  state_t     w_state_nxt;
  logic [3:0] w_prev_nxt;
  logic [3:0] w_match_nxt;
  logic [3:0] w_miss_nxt;
  logic [3:0] w_succ;
  logic [3:0] w_match_inc;
  logic [3:0] w_miss_inc;
  logic       w_legal;
  logic       w_hit;
  logic       w_err_nxt;
  logic       w_wrap_nxt;
  logic       w_locked_nxt;
  logic [3:0] w_expected_nxt;

  assign w_succ      = succ(r_prev);
  assign w_legal     = (mon.count_in >= 4'd1) && (mon.count_in <= 4'd10);
  assign w_hit       = (mon.count_in == w_succ);
  assign w_match_inc = 4'(r_match + 4'd1);
  assign w_miss_inc  = 4'(r_miss + 4'd1);

  // State register plus registered outputs and saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_HUNT;
      r_prev       <= 4'd0;
      r_match      <= 4'd0;
      r_miss       <= 4'd0;
      r_locked     <= 1'b0;
      r_expected   <= 4'd0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_match      <= w_match_nxt;
      r_miss       <= w_miss_nxt;
      r_locked     <= w_locked_nxt;
      r_expected   <= w_expected_nxt;
      r_err_pulse  <= w_err_nxt;
      r_wrap_pulse <= w_wrap_nxt;
      if (w_err_nxt && (r_err_count != {CNT_W{1'b1}}))
        r_err_count <= CNT_W'(r_err_count + 1'b1);
      if (w_wrap_nxt && (r_wrap_count != {CNT_W{1'b1}}))
        r_wrap_count <= CNT_W'(r_wrap_count + 1'b1);
    end
  end

  // Next-state: hunt for a legal value, confirm LOCK_LEN in a row, then flywheel
  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_match_nxt = r_match;
    w_miss_nxt  = r_miss;
    case (r_state)
      ST_HUNT: begin
        if (mon.count_valid && w_legal) begin
          w_prev_nxt  = mon.count_in;
          w_match_nxt = 4'd1;
          w_state_nxt = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (mon.count_valid) begin
          if (!w_legal) begin
            w_state_nxt = ST_HUNT;
            w_match_nxt = 4'd0;
          end else if (w_hit) begin
            w_prev_nxt  = mon.count_in;
            w_match_nxt = w_match_inc;
            if (w_match_inc == LOCK_V) begin
              w_state_nxt = ST_LOCKED;
              w_miss_nxt  = 4'd0;
            end
          end else begin
            w_prev_nxt  = mon.count_in;
            w_match_nxt = 4'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (mon.count_valid) begin
          if (w_hit) begin
            w_prev_nxt = mon.count_in;
            w_miss_nxt = 4'd0;
          end else if (w_miss_inc == UNLOCK_V) begin
            w_state_nxt = ST_HUNT;
            w_prev_nxt  = 4'd0;
            w_match_nxt = 4'd0;
            w_miss_nxt  = 4'd0;
          end else begin
            w_prev_nxt = w_succ;
            w_miss_nxt = w_miss_inc;
          end
        end
      end
      default: begin
        w_state_nxt = ST_HUNT;
        w_prev_nxt  = 4'd0;
        w_match_nxt = 4'd0;
        w_miss_nxt  = 4'd0;
      end
    endcase
  end

  // Output decode: pulses only for valid samples taken while locked
  always_comb begin
    w_err_nxt      = 1'b0;
    w_wrap_nxt     = 1'b0;
    w_locked_nxt   = (w_state_nxt == ST_LOCKED);
    w_expected_nxt = 4'd0;
    if (mon.count_valid && (r_state == ST_LOCKED)) begin
      w_err_nxt  = !w_hit;
      w_wrap_nxt = w_hit && (r_prev == 4'd10);
    end
    if (w_locked_nxt)
      w_expected_nxt = succ(w_prev_nxt);
  end

  assign mon.locked     = r_locked;
  assign mon.expected   = r_expected;
  assign mon.err_pulse  = r_err_pulse;
  assign mon.wrap_pulse = r_wrap_pulse;
  assign mon.err_count  = r_err_count;
  assign mon.wrap_count = r_wrap_count;

endmodule

// File: tb/tb_decade_count_monitor.sv
// Scoreboard bench for decade_count_monitor: a behavioural model queues the
// expected outputs for every driven cycle; scenario tasks pop and compare.
module tb_decade_count_monitor;

  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  decade_count_monitor_if #(.CNT_W(CW)) bus();

  decade_count_monitor #(
    .LOCK_LEN(3), .UNLOCK_LEN(2), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mon(bus)
  );

  typedef struct packed {
    logic          locked;
    logic [3:0]    expected;
    logic          err;
    logic          wrap;
    logic [CW-1:0] errc;
    logic [CW-1:0] wrapc;
  } obs_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: 0 hunt, 1 sync, 2 locked
  int         m_st = 0;
  logic [3:0] m_prev = 0, m_match = 0, m_miss = 0;
  logic [CW-1:0] m_errc = 0, m_wrapc = 0;
  logic       m_err = 0, m_wrap = 0;

  function automatic logic [3:0] nxt(input logic [3:0] v);
    if (v == 4'd10) return 4'd1;
    return 4'(v + 4'd1);
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.locked   = bus.locked;
    o.expected = bus.expected;
    o.err      = bus.err_pulse;
    o.wrap     = bus.wrap_pulse;
    o.errc     = bus.err_count;
    o.wrapc    = bus.wrap_count;
    return o;
  endfunction

  task automatic model_step(input logic [3:0] v, input logic vld, input logic rst);
    logic ok;
    logic [3:0] e;
    ok = (v >= 4'd1) && (v <= 4'd10);
    m_err = 1'b0;
    m_wrap = 1'b0;
    if (rst) begin
      m_st = 0; m_prev = 0; m_match = 0; m_miss = 0; m_errc = 0; m_wrapc = 0;
    end else if (vld) begin
      if (m_st == 0) begin
        if (ok) begin m_prev = v; m_match = 1; m_st = 1; end
      end else if (m_st == 1) begin
        if (!ok) begin m_st = 0; m_match = 0; end
        else if (v == nxt(m_prev)) begin
          m_prev = v; m_match = m_match + 4'd1;
          if (m_match == 4'd3) begin m_st = 2; m_miss = 0; end
        end else begin m_prev = v; m_match = 1; end
      end else begin
        e = nxt(m_prev);
        if (v == e) begin
          if (m_prev == 4'd10) m_wrap = 1'b1;
          m_prev = v; m_miss = 0;
        end else begin
          m_err = 1'b1; m_prev = e; m_miss = m_miss + 4'd1;
          if (m_miss == 4'd2) begin m_st = 0; m_prev = 0; m_match = 0; m_miss = 0; end
        end
      end
      if (m_err && m_errc != {CW{1'b1}}) m_errc = m_errc + 1'b1;
      if (m_wrap && m_wrapc != {CW{1'b1}}) m_wrapc = m_wrapc + 1'b1;
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic vld, input logic rst);
    obs_t e;
    bus.count_in = v;
    bus.count_valid = vld;
    reset = rst;
    model_step(v, vld, rst);
    e.locked   = (m_st == 2);
    e.expected = (m_st == 2) ? nxt(m_prev) : 4'd0;
    e.err      = m_err;
    e.wrap     = m_wrap;
    e.errc     = m_errc;
    e.wrapc    = m_wrapc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    drive(4'd0, 1'b0, 1'b1);
    drive(4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
      if (i == 1) begin
        o = observe();
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_sb got %h want %h", o, e); end
        n_cmp++;
        if (o !== obs_t'(0)) begin n_bad++; $display("FAIL reset_zero got %h want 0", o); end
      end
    end
  endtask

  task automatic test_lock_wrap();
    obs_t e, o;
    logic [3:0] seq [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd1, 4'd2};
    for (int i = 0; i < 12; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL lock_wrap[%0d] got %h want %h", i, o, e); end
      if (i == 1) begin
        n_cmp++;
        if (o.locked !== 1'b0) begin n_bad++; $display("FAIL early_lock got %b want 0", o.locked); end
      end
      if (i == 2) begin
        n_cmp++;
        if (o.locked !== 1'b1 || o.expected !== 4'd4) begin
          n_bad++; $display("FAIL lock_at_3 got locked=%b exp=%0d want 1/4", o.locked, o.expected);
        end
      end
      if (i == 10) begin
        n_cmp++;
        if (o.wrap !== 1'b1 || o.wrapc !== 4'd1 || o.errc !== 4'd0) begin
          n_bad++; $display("FAIL first_wrap got wrap=%b wc=%0d ec=%0d want 1/1/0", o.wrap, o.wrapc, o.errc);
        end
      end
    end
  endtask

  task automatic test_single_error();
    obs_t e, o;
    logic [3:0] seq [6] = '{4'd3, 4'd4, 4'd5, 4'd9, 4'd7, 4'd8};
    for (int i = 0; i < 6; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL single_err[%0d] got %h want %h", i, o, e); end
      if (i == 3) begin
        n_cmp++;
        if (o.err !== 1'b1 || o.errc !== 4'd1 || o.locked !== 1'b1 || o.expected !== 4'd7) begin
          n_bad++; $display("FAIL flywheel got %h want err=1 ec=1 locked=1 exp=7", o);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (o.err !== 1'b0 || o.expected !== 4'd8 || o.locked !== 1'b1) begin
          n_bad++; $display("FAIL resume got %h want err=0 exp=8 locked=1", o);
        end
      end
    end
  endtask

  task automatic test_unlock_relock();
    obs_t e, o;
    logic [3:0] seq [5] = '{4'd0, 4'd15, 4'd4, 4'd5, 4'd6};
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL unlock[%0d] got %h want %h", i, o, e); end
      if (i == 1) begin
        n_cmp++;
        if (o.locked !== 1'b0 || o.expected !== 4'd0 || o.err !== 1'b1 || o.errc !== 4'd3) begin
          n_bad++; $display("FAIL drop_lock got %h want locked=0 exp=0 err=1 ec=3", o);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (o.locked !== 1'b1 || o.expected !== 4'd7) begin
          n_bad++; $display("FAIL relock got locked=%b exp=%0d want 1/7", o.locked, o.expected);
        end
      end
    end
  endtask

  task automatic test_valid_hold();
    obs_t e, o, snap;
    snap = observe();
    for (int i = 0; i < 5; i++) begin
      drive(4'($urandom_range(0, 15)), 1'b0, 1'b0);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL hold_sb[%0d] got %h want %h", i, o, e); end
      n_cmp++;
      if (o !== snap) begin n_bad++; $display("FAIL hold_frozen[%0d] got %h want %h", i, o, snap); end
    end
  endtask

  task automatic test_wrap_saturation();
    obs_t e, o;
    for (int v = 7; v <= 10; v++) begin
      drive(4'(v), 1'b1, 1'b0);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL sat_lead[%0d] got %h want %h", v, o, e); end
    end
    for (int d = 0; d < 30; d++) begin
      for (int v = 1; v <= 10; v++) begin
        drive(4'(v), 1'b1, 1'b0);
        e = sb.pop_front();
        o = observe();
        n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL sat[%0d.%0d] got %h want %h", d, v, o, e); end
      end
    end
    n_cmp++;
    if (o.wrapc !== 4'd15 || o.locked !== 1'b1 || o.errc !== 4'd3) begin
      n_bad++; $display("FAIL wrap_sat got wc=%0d locked=%b ec=%0d want 15/1/3", o.wrapc, o.locked, o.errc);
    end
  endtask

  task automatic test_reset_mid_stream();
    obs_t e, o;
    drive(4'd1, 1'b1, 1'b1);
    e = sb.pop_front();
    o = observe();
    n_cmp++;
    if (o !== obs_t'(0)) begin n_bad++; $display("FAIL mid_reset got %h want 0", o); end
    n_cmp++;
    if (o !== e) begin n_bad++; $display("FAIL mid_reset_sb got %h want %h", o, e); end
    for (int v = 1; v <= 3; v++) begin
      drive(4'(v), 1'b1, 1'b0);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL post_reset[%0d] got %h want %h", v, o, e); end
    end
    n_cmp++;
    if (o.locked !== 1'b1 || o.expected !== 4'd4) begin
      n_bad++; $display("FAIL post_reset_lock got locked=%b exp=%0d want 1/4", o.locked, o.expected);
    end
  endtask

  task automatic test_back_to_back_resync();
    obs_t e, o;
    logic [3:0] seq [8] = '{4'd0, 4'd5, 4'd7, 4'd12, 4'd13, 4'd2, 4'd3, 4'd4};
    drive(4'd0, 1'b0, 1'b1);
    e = sb.pop_front();
    for (int i = 0; i < 8; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      e = sb.pop_front();
      o = observe();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL resync[%0d] got %h want %h", i, o, e); end
      if (i == 6) begin
        n_cmp++;
        if (o.locked !== 1'b0) begin n_bad++; $display("FAIL resync_early got locked=%b want 0", o.locked); end
      end
    end
    n_cmp++;
    if (o.locked !== 1'b1 || o.expected !== 4'd5 || o.errc !== 4'd0) begin
      n_bad++; $display("FAIL resync_lock got locked=%b exp=%0d ec=%0d want 1/5/0", o.locked, o.expected, o.errc);
    end
  endtask

  initial begin
    bus.count_in = 4'd0;
    bus.count_valid = 1'b0;
    #2;
    test_reset();
    test_lock_wrap();
    test_single_error();
    test_unlock_relock();
    test_valid_hold();
    test_wrap_saturation();
    test_reset_mid_stream();
    test_back_to_back_resync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
